// File: rtl/fp_gpio_pkg.sv
// Shared front-panel GPIO constants: default masks and pin-bit positions.
// Constants only; no timing or flow control.
package fp_gpio_pkg;

    localparam int FP_GPIO_W = 12;

    typedef logic [FP_GPIO_W-1:0] fp_gpio_word_t;

    localparam fp_gpio_word_t SYNC_OUT_MASK = 12'h555;
    localparam fp_gpio_word_t TX_OUT_MASK   = 12'h800;
    localparam fp_gpio_word_t IN_MASK       = 12'h022;

    localparam fp_gpio_word_t DEF_OUT_MASK  = SYNC_OUT_MASK | TX_OUT_MASK;
    localparam fp_gpio_word_t DEF_IO_DDR    = SYNC_OUT_MASK | TX_OUT_MASK;

    localparam fp_gpio_word_t PIN_SYNC    = 12'h001;
    localparam fp_gpio_word_t PIN_LOAD    = 12'h004;
    localparam fp_gpio_word_t PIN_DATA    = 12'h010;
    localparam fp_gpio_word_t PIN_PHI_BAR = 12'h040;
    localparam fp_gpio_word_t PIN_PHI     = 12'h100;
    localparam fp_gpio_word_t PIN_ID      = 12'h400;
    localparam fp_gpio_word_t PIN_TX      = 12'h800;

endpackage

// File: rtl/tick_divider.sv
// Free-running divide-by-FAC counter with a one-cycle tick on the last count
// and a registered divided clock (tick is combinational, div_clk one flop); no backpressure.
module tick_divider #(
    parameter int FAC = 10,
    parameter int CW  = (FAC > 1) ? $clog2(FAC) : 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic div_clk
);

    localparam logic [CW-1:0] LAST = CW'(FAC - 1);
    // Threshold rounds up so odd factors get the extra cycle in the low phase.
    localparam logic [CW-1:0] HIGH_FROM = CW'(FAC - FAC / 2);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            div_clk <= (cnt >= HIGH_FROM);
        end
    end

endmodule

// File: rtl/fp_gpio_bridge.sv
// Masked front-panel GPIO bridge updated once per CLK_DIV_FAC cycles; outputs land on the
// next tick edge, inputs after a 2-flop synchronizer plus the next tick. No backpressure.
module fp_gpio_bridge
    import fp_gpio_pkg::*;
#(
    parameter int                        GPIO_REG_WIDTH = 12,
    parameter int                        CLK_DIV_FAC    = 10,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = DEF_OUT_MASK,
    parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK        = fp_gpio_pkg::IN_MASK,
    parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR         = DEF_IO_DDR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] gpio_in,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic                      div_clk,
    output logic                      tick
);

    logic [GPIO_REG_WIDTH-1:0] sync1;
    logic [GPIO_REG_WIDTH-1:0] sync2;

    tick_divider #(
        .FAC (CLK_DIV_FAC)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .div_clk (div_clk)
    );

    assign fp_gpio_ddr = IO_DDR;

    // Synchronizer runs every cycle so the tick edge always sees a settled word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= fp_gpio_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_in     <= '0;
            fp_gpio_out <= '0;
        end else if (tick) begin
            gpio_in     <= sync2 & IN_MASK;
            fp_gpio_out <= gpio_out & OUT_MASK;
        end
    end

endmodule

// File: tb/tb_fp_gpio_bridge.sv
module tb_fp_gpio_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] gpio_out = 12'h000;
    logic [11:0] fp_gpio_in = 12'h000;

    logic [11:0] gpio_in, fp_gpio_out, fp_gpio_ddr;
    logic        div_clk, tick;
    logic [11:0] gpio_in3, fp_gpio_out3, fp_gpio_ddr3;
    logic        div_clk3, tick3;

    int k;
    int vec;
    int errs;

    always #5 clk = ~clk;

    fp_gpio_bridge #(.CLK_DIV_FAC(10)) dut (
        .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr),
        .div_clk(div_clk), .tick(tick)
    );

    fp_gpio_bridge #(.CLK_DIV_FAC(3)) dut3 (
        .clk(clk), .reset(reset), .gpio_out(gpio_out), .gpio_in(gpio_in3),
        .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out3), .fp_gpio_ddr(fp_gpio_ddr3),
        .div_clk(div_clk3), .tick(tick3)
    );

    // One rising edge, then sample/drive on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        k = 0;
    endtask

    task automatic test_reset();
        gpio_out   = 12'hFFF;
        fp_gpio_in = 12'h000;
        reset      = 1'b0;
        repeat (3) step();
        vec++; if (fp_gpio_out !== 12'h000) begin errs++; $display("FAIL rst_out got %h want 000", fp_gpio_out); end
        vec++; if (gpio_in !== 12'h000) begin errs++; $display("FAIL rst_in got %h want 000", gpio_in); end
        vec++; if (div_clk !== 1'b0) begin errs++; $display("FAIL rst_divclk got %b want 0", div_clk); end
        vec++; if (tick !== 1'b0) begin errs++; $display("FAIL rst_tick got %b want 0", tick); end
        vec++; if (fp_gpio_ddr !== 12'hD55) begin errs++; $display("FAIL rst_ddr got %h want d55", fp_gpio_ddr); end
        vec++; if (fp_gpio_ddr3 !== 12'hD55) begin errs++; $display("FAIL rst_ddr3 got %h want d55", fp_gpio_ddr3); end
    endtask

    task automatic test_divider();
        logic        e_tick, e_div;
        logic [11:0] e_out;
        release_reset();
        for (int i = 0; i < 30; i++) begin
            step();
            e_tick = (k % 10 == 9);
            e_div  = (k >= 6) && ((k % 10 >= 6) || (k % 10 == 0));
            e_out  = (k >= 10) ? 12'hD55 : 12'h000;
            vec++; if (tick !== e_tick) begin errs++; $display("FAIL div_tick k=%0d got %b want %b", k, tick, e_tick); end
            vec++; if (div_clk !== e_div) begin errs++; $display("FAIL div_clk k=%0d got %b want %b", k, div_clk, e_div); end
            vec++; if (fp_gpio_out !== e_out) begin errs++; $display("FAIL first_out k=%0d got %h want %h", k, fp_gpio_out, e_out); end
            vec++; if (fp_gpio_ddr !== 12'hD55) begin errs++; $display("FAIL ddr k=%0d got %h want d55", k, fp_gpio_ddr); end
        end
    endtask

    task automatic test_input();
        fp_gpio_in = 12'hFFF;
        run_to(39);
        vec++; if (gpio_in !== 12'h000) begin errs++; $display("FAIL in_pre got %h want 000", gpio_in); end
        step();
        vec++; if (gpio_in !== 12'h022) begin errs++; $display("FAIL in_fff got %h want 022", gpio_in); end
        fp_gpio_in = 12'h020;
        run_to(49);
        vec++; if (gpio_in !== 12'h022) begin errs++; $display("FAIL in_hold got %h want 022", gpio_in); end
        step();
        vec++; if (gpio_in !== 12'h020) begin errs++; $display("FAIL in_020 got %h want 020", gpio_in); end
    endtask

    task automatic test_late_toggle();
        run_to(59);
        fp_gpio_in = 12'h002;
        step();
        vec++; if (gpio_in !== 12'h020) begin errs++; $display("FAIL late_same got %h want 020", gpio_in); end
        run_to(69);
        vec++; if (gpio_in !== 12'h020) begin errs++; $display("FAIL late_hold got %h want 020", gpio_in); end
        step();
        vec++; if (gpio_in !== 12'h002) begin errs++; $display("FAIL late_next got %h want 002", gpio_in); end
    endtask

    task automatic test_out_sampling();
        run_to(71);
        gpio_out = 12'h000;
        run_to(75);
        vec++; if (fp_gpio_out !== 12'hD55) begin errs++; $display("FAIL out_between got %h want d55", fp_gpio_out); end
        gpio_out = 12'hFFF;
        run_to(80);
        vec++; if (fp_gpio_out !== 12'hD55) begin errs++; $display("FAIL out_lost got %h want d55", fp_gpio_out); end
        gpio_out = 12'h0F0;
        run_to(89);
        vec++; if (fp_gpio_out !== 12'hD55) begin errs++; $display("FAIL out_hold got %h want d55", fp_gpio_out); end
        step();
        vec++; if (fp_gpio_out !== 12'h050) begin errs++; $display("FAIL out_0f0 got %h want 050", fp_gpio_out); end
    endtask

    task automatic test_reset_mid();
        gpio_out = 12'h555;
        run_to(100);
        vec++; if (fp_gpio_out !== 12'h555) begin errs++; $display("FAIL mid_pre got %h want 555", fp_gpio_out); end
        run_to(104);
        reset = 1'b0;
        #1;
        vec++; if (fp_gpio_out !== 12'h000) begin errs++; $display("FAIL mid_out got %h want 000", fp_gpio_out); end
        vec++; if (gpio_in !== 12'h000) begin errs++; $display("FAIL mid_in got %h want 000", gpio_in); end
        vec++; if (div_clk !== 1'b0) begin errs++; $display("FAIL mid_divclk got %b want 0", div_clk); end
        vec++; if (tick !== 1'b0) begin errs++; $display("FAIL mid_tick got %b want 0", tick); end
        vec++; if (fp_gpio_ddr !== 12'hD55) begin errs++; $display("FAIL mid_ddr got %h want d55", fp_gpio_ddr); end
        step();
        step();
        release_reset();
        run_to(9);
        vec++; if (fp_gpio_out !== 12'h000) begin errs++; $display("FAIL post_out9 got %h want 000", fp_gpio_out); end
        vec++; if (tick !== 1'b1) begin errs++; $display("FAIL post_tick9 got %b want 1", tick); end
        step();
        vec++; if (fp_gpio_out !== 12'h555) begin errs++; $display("FAIL post_out10 got %h want 555", fp_gpio_out); end
        vec++; if (gpio_in !== 12'h002) begin errs++; $display("FAIL post_in10 got %h want 002", gpio_in); end
    endtask

    task automatic test_div3();
        logic        e_tick, e_div;
        logic [11:0] e_out;
        reset = 1'b0;
        step();
        gpio_out = 12'hFFF;
        release_reset();
        for (int i = 0; i < 9; i++) begin
            step();
            e_tick = (k % 3 == 2);
            e_div  = (k >= 3) && (k % 3 == 0);
            e_out  = (k >= 3) ? 12'hD55 : 12'h000;
            vec++; if (tick3 !== e_tick) begin errs++; $display("FAIL div3_tick k=%0d got %b want %b", k, tick3, e_tick); end
            vec++; if (div_clk3 !== e_div) begin errs++; $display("FAIL div3_clk k=%0d got %b want %b", k, div_clk3, e_div); end
            vec++; if (fp_gpio_out3 !== e_out) begin errs++; $display("FAIL div3_out k=%0d got %h want %h", k, fp_gpio_out3, e_out); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        k    = 0;
        vec  = 0;
        errs = 0;
        test_reset();
        test_divider();
        test_input();
        test_late_toggle();
        test_out_sampling();
        test_reset_mid();
        test_div3();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
